// File: rtl/bjack_ctrl.sv
// Blackjack dealer controller: requests cards, keeps the hard sum and ace flag,
// and finishes each hand with a registered stand or bust verdict.
module bjack_ctrl #(
  parameter int STAND_LIMIT = 17,
  parameter int MAX_CARDS   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CARD_VALID,
  input  logic [3:0] CARD_VALUE,
  output logic       CARD_REQ,
  output logic [5:0] SCORE,
  output logic       STAND,
  output logic       BUST,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EVAL, ST_DONE} state_t;

  localparam logic [5:0] LIMIT = 6'(STAND_LIMIT);
  localparam logic [2:0] MAXC  = 3'(MAX_CARDS);

  state_t     state;
  logic [5:0] hsum;
  logic       ace_seen;
  logic [2:0] cnt;

  logic       val_ok, card_ok, card_bad;
  logic [5:0] hsum_nxt, score_nxt;
  logic       ace_nxt;

  assign val_ok   = (CARD_VALUE != 4'd0) && (CARD_VALUE <= 4'd10);
  assign card_ok  = CARD_REQ && CARD_VALID && val_ok;
  assign card_bad = CARD_REQ && CARD_VALID && !val_ok;

  // SCORE is registered on the accepting edge so EVAL already shows the new total.
  assign hsum_nxt  = hsum + {2'b00, CARD_VALUE};
  assign ace_nxt   = ace_seen | (CARD_VALUE == 4'd1);
  assign score_nxt = (ace_nxt && hsum_nxt <= 6'd11) ? hsum_nxt + 6'd10 : hsum_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      hsum     <= '0;
      ace_seen <= 1'b0;
      cnt      <= '0;
      CARD_REQ <= 1'b0;
      SCORE    <= '0;
      STAND    <= 1'b0;
      BUST     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state    <= ST_WAIT;
            hsum     <= '0;
            ace_seen <= 1'b0;
            cnt      <= '0;
            SCORE    <= '0;
            STAND    <= 1'b0;
            BUST     <= 1'b0;
            DONE     <= 1'b0;
            CARD_REQ <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (card_ok) begin
            state    <= ST_EVAL;
            hsum     <= hsum_nxt;
            ace_seen <= ace_nxt;
            cnt      <= cnt + 3'd1;
            SCORE    <= score_nxt;
            CARD_REQ <= 1'b0;
          end else if (card_bad) begin
            ERR <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (hsum > 6'd21) begin
            state <= ST_DONE;
            BUST  <= 1'b1;
            DONE  <= 1'b1;
          end else if (SCORE >= LIMIT || cnt == MAXC) begin
            state <= ST_DONE;
            STAND <= 1'b1;
            DONE  <= 1'b1;
          end else begin
            state    <= ST_WAIT;
            CARD_REQ <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bjack_ctrl.sv
// Bench for bjack_ctrl: directed hands plus random hands against a card-list model.
module tb_bjack_ctrl;
  localparam int SL = 17;
  localparam int MC = 5;

  logic       CLK = 1'b0;
  logic       RST, START, CARD_VALID;
  logic [3:0] CARD_VALUE;
  logic       CARD_REQ, STAND, BUST, DONE, ERR;
  logic [5:0] SCORE;

  int checks = 0;
  int errors = 0;

  int m_hsum, m_ace, m_cnt;

  bjack_ctrl #(.STAND_LIMIT(SL), .MAX_CARDS(MC)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CARD_VALID(CARD_VALID),
    .CARD_VALUE(CARD_VALUE), .CARD_REQ(CARD_REQ), .SCORE(SCORE),
    .STAND(STAND), .BUST(BUST), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      checks++;
      if (STAND === 1'b1 && BUST === 1'b1) begin
        errors++;
        $display("FAIL stand_and_bust got %b%b exp not both", STAND, BUST);
      end
    end
  end

  // Best total: an ace is worth 11 if that keeps the hand at 21 or below.
  function automatic int m_score();
    return (m_ace != 0 && m_hsum + 10 <= 21) ? m_hsum + 10 : m_hsum;
  endfunction

  task automatic wait_req();
    int n = 0;
    while (CARD_REQ !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (CARD_REQ !== 1'b1) begin
      errors++;
      $display("FAIL wait_req got %b exp 1 within 50 cycles", CARD_REQ);
    end
  endtask

  task automatic start_hand();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    m_hsum = 0; m_ace = 0; m_cnt = 0;
    checks++;
    if ({CARD_REQ, DONE, STAND, BUST, ERR, SCORE} !== {5'b10000, 6'd0}) begin
      errors++;
      $display("FAIL start_hand got %h exp %h", {CARD_REQ, DONE, STAND, BUST, ERR, SCORE}, {5'b10000, 6'd0});
    end
  endtask

  task automatic play_card(input int v, input bit stray, output bit over);
    int sc;
    bit b, s;
    over = 1'b0;
    CARD_VALID = 1'b1;
    CARD_VALUE = 4'(v);
    @(negedge CLK);
    if (v >= 1 && v <= 10) begin
      CARD_VALID = stray;
      CARD_VALUE = 4'($urandom_range(1, 10));
      m_hsum += v;
      if (v == 1) m_ace = 1;
      m_cnt++;
      sc = m_score();
      checks++;
      if ({CARD_REQ, ERR, DONE, SCORE} !== {3'b000, 6'(sc)}) begin
        errors++;
        $display("FAIL eval_score got %h exp %h", {CARD_REQ, ERR, DONE, SCORE}, {3'b000, 6'(sc)});
      end
      @(negedge CLK);
      CARD_VALID = 1'b0;
      b = (m_hsum > 21);
      s = !b && (sc >= SL || m_cnt == MC);
      over = b | s;
      checks++;
      if ({DONE, STAND, BUST, CARD_REQ, SCORE} !== {over, s, b, !over, 6'(sc)}) begin
        errors++;
        $display("FAIL decide got %h exp %h", {DONE, STAND, BUST, CARD_REQ, SCORE}, {over, s, b, !over, 6'(sc)});
      end
    end else begin
      CARD_VALID = 1'b0;
      sc = m_score();
      checks++;
      if ({ERR, CARD_REQ, DONE, SCORE} !== {3'b110, 6'(sc)}) begin
        errors++;
        $display("FAIL err_pulse got %h exp %h", {ERR, CARD_REQ, DONE, SCORE}, {3'b110, 6'(sc)});
      end
      @(negedge CLK);
      checks++;
      if ({ERR, CARD_REQ, SCORE} !== {2'b01, 6'(sc)}) begin
        errors++;
        $display("FAIL err_clear got %h exp %h", {ERR, CARD_REQ, SCORE}, {2'b01, 6'(sc)});
      end
    end
  endtask

  task automatic deal(input int v);
    bit over;
    wait_req();
    play_card(v, 1'b0, over);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({CARD_REQ, DONE, STAND, BUST, ERR, SCORE} !== 11'd0) begin
      errors++;
      $display("FAIL reset got %h exp 0", {CARD_REQ, DONE, STAND, BUST, ERR, SCORE});
    end
    RST = 1'b0;
    @(negedge CLK);
    CARD_VALID = 1'b1; CARD_VALUE = 4'd5;
    repeat (2) @(negedge CLK);
    CARD_VALID = 1'b0;
    checks++;
    if ({CARD_REQ, ERR, SCORE, dut.cnt} !== 11'd0) begin
      errors++;
      $display("FAIL idle_ignore got %h exp 0", {CARD_REQ, ERR, SCORE, dut.cnt});
    end
  endtask

  task automatic test_hard_stand();
    start_hand();
    deal(10); deal(7);
    checks++;
    if ({SCORE, STAND, DONE, BUST} !== {6'd17, 3'b110}) begin
      errors++;
      $display("FAIL hard17 got %h exp %h", {SCORE, STAND, DONE, BUST}, {6'd17, 3'b110});
    end
  endtask

  task automatic test_soft_restart();
    start_hand();
    deal(1); deal(6);
    repeat (3) @(negedge CLK);
    checks++;
    if ({SCORE, STAND, DONE, BUST, CARD_REQ} !== {6'd17, 4'b1100}) begin
      errors++;
      $display("FAIL soft17_hold got %h exp %h", {SCORE, STAND, DONE, BUST, CARD_REQ}, {6'd17, 4'b1100});
    end
    start_hand();
  endtask

  task automatic test_bust();
    start_hand();
    deal(10); deal(6); deal(9);
    CARD_VALID = 1'b1; CARD_VALUE = 4'd3;
    repeat (4) @(negedge CLK);
    CARD_VALID = 1'b0;
    checks++;
    if ({SCORE, BUST, STAND, DONE, CARD_REQ, ERR} !== {6'd25, 5'b10100}) begin
      errors++;
      $display("FAIL bust25 got %h exp %h", {SCORE, BUST, STAND, DONE, CARD_REQ, ERR}, {6'd25, 5'b10100});
    end
  endtask

  task automatic test_invalid_card();
    start_hand();
    deal(1); deal(1);
    deal(12);
    checks++;
    if (SCORE !== 6'd12) begin
      errors++;
      $display("FAIL ace_pair got %0d exp 12", SCORE);
    end
    deal(5);
    checks++;
    if ({SCORE, STAND, dut.cnt} !== {6'd17, 1'b1, 3'd3}) begin
      errors++;
      $display("FAIL invalid_final got %h exp %h", {SCORE, STAND, dut.cnt}, {6'd17, 1'b1, 3'd3});
    end
  endtask

  task automatic test_max_cards();
    start_hand();
    for (int i = 0; i < 5; i++) deal(2);
    checks++;
    if ({SCORE, STAND, BUST, DONE} !== {6'd10, 3'b101}) begin
      errors++;
      $display("FAIL max_cards got %h exp %h", {SCORE, STAND, BUST, DONE}, {6'd10, 3'b101});
    end
  endtask

  task automatic test_reset_in_eval();
    start_hand();
    CARD_VALID = 1'b1; CARD_VALUE = 4'd9;
    @(negedge CLK);
    CARD_VALID = 1'b0;
    RST = 1'b1; START = 1'b1;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    checks++;
    if ({CARD_REQ, DONE, STAND, BUST, ERR, SCORE, dut.hsum, dut.ace_seen, dut.cnt} !== 21'd0) begin
      errors++;
      $display("FAIL rst_eval got %h exp 0", {CARD_REQ, DONE, STAND, BUST, ERR, SCORE, dut.hsum, dut.ace_seen, dut.cnt});
    end
    CARD_VALID = 1'b1; CARD_VALUE = 4'd4;
    repeat (3) @(negedge CLK);
    CARD_VALID = 1'b0;
    checks++;
    if ({CARD_REQ, ERR, DONE, SCORE} !== 9'd0) begin
      errors++;
      $display("FAIL rst_ignore got %h exp 0", {CARD_REQ, ERR, DONE, SCORE});
    end
  endtask

  task automatic test_random();
    bit over;
    int v, guard;
    for (int h = 0; h < 40; h++) begin
      start_hand();
      over = 1'b0;
      guard = 0;
      while (!over && guard < 30) begin
        guard++;
        wait_req();
        if ($urandom_range(0, 5) == 0) begin
          START = 1'b1;
          @(negedge CLK);
          START = 1'b0;
          checks++;
          if ({CARD_REQ, DONE, SCORE, dut.cnt} !== {2'b10, 6'(m_score()), 3'(m_cnt)}) begin
            errors++;
            $display("FAIL start_in_wait got %h exp %h", {CARD_REQ, DONE, SCORE, dut.cnt}, {2'b10, 6'(m_score()), 3'(m_cnt)});
          end
        end
        if ($urandom_range(0, 7) == 0)
          v = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(11, 15));
        else
          v = int'($urandom_range(1, 10));
        play_card(v, 1'($urandom_range(0, 1)), over);
      end
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; CARD_VALID = 1'b0; CARD_VALUE = 4'd0;
    @(negedge CLK);
    test_reset();
    test_hard_stand();
    test_soft_restart();
    test_bust();
    test_invalid_card();
    test_max_cards();
    test_reset_in_eval();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bjack_ctrl.md
BJACK_CTRL -- requirements
Module: bjack_ctrl

Interface
REQ-001 SHALL have parameter STAND_LIMIT, default 17: the dealer stands when SCORE >= STAND_LIMIT (legal range 12..21).
REQ-002 SHALL have parameter MAX_CARDS, default 5: the hand ends with a stand once this many cards are accepted without a bust (legal range 2..7).
REQ-003 SHALL have port CLK  in  1: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port RST  in  1: reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port START  in  1: one-cycle request to begin a new hand.
REQ-006 SHALL have port CARD_VALID  in  1: CARD_VALUE holds a dealt card this cycle.
REQ-007 SHALL have port CARD_VALUE  in  4: card rank; 1 = ace, 2..10 = face value; 0 and 11..15 are invalid.
REQ-008 SHALL have port CARD_REQ  out  1: the controller requests a card.
REQ-009 SHALL have port SCORE  out  6: best hand total, with an ace counted as 11 when that does not exceed 21.
REQ-010 SHALL have port STAND  out  1: level; the hand ended without a bust.
REQ-011 SHALL have port BUST  out  1: level; the hand ended with the hard total above 21.
REQ-012 SHALL have port DONE  out  1: level; the hand is finished.
REQ-013 SHALL have port ERR  out  1: one-cycle pulse when an invalid card is offered during a handshake.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT, EVAL and DONE; all outputs are registered.
REQ-015 SHALL keep internal registers: 6-bit hard sum HSUM (ace counted as 1), 1-bit ACE_SEEN, and 3-bit card count CNT.
REQ-016 SHALL derive SCORE as HSUM+10 when ACE_SEEN=1 and HSUM+10 <= 21, and as HSUM otherwise.
REQ-017 SHALL, on START=1 in IDLE or DONE, clear HSUM/ACE_SEEN/CNT/STAND/BUST/DONE and enter WAIT with CARD_REQ=1 on the next cycle.
REQ-018 SHALL ignore START while in WAIT or EVAL.
REQ-019 SHALL accept a card only on a cycle where CARD_REQ=1, CARD_VALID=1 and CARD_VALUE is in 1..10.
REQ-020 SHALL, on acceptance, add the value to HSUM, set ACE_SEEN if the value is 1, increment CNT, enter EVAL and drop CARD_REQ, all on that edge.
REQ-021 SHALL, in the cycle after acceptance (EVAL), present the updated SCORE.
REQ-022 SHALL decide at the edge ending EVAL, in priority order: HSUM > 21 -> DONE with BUST=1; else SCORE >= STAND_LIMIT or CNT == MAX_CARDS -> DONE with STAND=1; else WAIT with CARD_REQ=1.
REQ-023 SHALL, on CARD_VALID=1 with an invalid CARD_VALUE while CARD_REQ=1, pulse ERR for exactly one cycle (the next), leave all state unchanged and keep CARD_REQ=1.
REQ-024 SHALL ignore CARD_VALID while CARD_REQ=0, with no ERR.
REQ-025 SHALL hold DONE=1, STAND/BUST and SCORE stable in DONE until START or RST.
REQ-026 SHALL never assert STAND and BUST together.
REQ-027 SHALL keep the minimum card-to-card request spacing at 2 cycles: accept at edge k, CARD_REQ high again after edge k+1.

Reset
REQ-028 SHALL, when RST=1 at a rising edge, enter IDLE with CARD_REQ=0, SCORE=0, STAND=0, BUST=0, DONE=0, ERR=0 and HSUM/ACE_SEEN/CNT cleared, regardless of state.
REQ-029 SHALL give RST priority over START and CARD_VALID in the same cycle.

Verification
REQ-030 SHALL be verified by this scenario: START; cards 10, 7 -> SCORE=17, STAND=1, DONE=1, BUST=0 one cycle after EVAL.
REQ-031 SHALL be verified by this scenario: START; cards 1, 6 -> soft SCORE=17, STAND=1; then START again -> SCORE=0, DONE=0, CARD_REQ=1.
REQ-032 SHALL be verified by this scenario: START; cards 10, 6, 9 -> SCORE=25, BUST=1, STAND=0, no further CARD_REQ.
REQ-033 SHALL be verified by this scenario: START; cards 1, 1, value 12 offered, 5 -> ERR one-cycle pulse on the 12 with SCORE held at 12; final SCORE=17, STAND=1, CNT=3.
REQ-034 SHALL be verified by this scenario: START; cards 2, 2, 2, 2, 2 (MAX_CARDS=5) -> SCORE=10, STAND=1 after the fifth card.
REQ-035 SHALL be verified by this scenario: START; card 9 accepted, RST asserted in EVAL -> next cycle all outputs 0 and state IDLE; CARD_VALID afterwards is ignored until START.
